md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide responder for the 5-stage pipeline; the EX stage issues MULT/DIV/MTHI/MTLO requests.
- The block answers with busy and holds architectural HI/LO.
- Pipeline hazard logic stalls D on any MFHI/MFLO/mult-div instruction while busy or start is high.
- The unit sits beside the ALU in EX; HI/LO read data goes to EX_MEM like ALUOut.

Parameters:
- MULT_CYCLES, 5, cycles busy is high for MULT/MULTU/MADD/MSUB (>=1).
- DIV_CYCLES, 10, cycles busy is high for DIV/DIVU (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request valid in EX this cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- a  in  32  forwarded rs value.
- b  in  32  forwarded rt value.
- busy  out  1  operation in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (rst=0, async): busy=0, hi=0, lo=0, counter=0, pending regs=0; FSM=IDLE. Reset mid-operation discards the in-flight result.
- FSM states are IDLE and RUN.
- IDLE with start=1 and op in {MULT,MULTU,DIV,DIVU}:
  - Latch the computed 64-bit result into pending {phi,plo}.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- IDLE with start=1 and op=MTHI: hi<=a at this edge, busy stays 0. op=MTLO: lo<=a likewise.
- RUN: counter decrements each cycle. At the edge where counter==1: hi<=phi, lo<=plo, busy<=0, go to IDLE.
  - busy is high for exactly N cycles; hi/lo show the new value in the first cycle busy is 0.
- start while busy=1 is ignored; hazard logic guarantees this never happens, and the bench checks it.
- start with busy=0 in the cycle following completion is accepted (back-to-back, no bubble).
- MULT: signed 32x32 -> 64; phi=upper, plo=lower. MULTU: unsigned.
- DIV signed: plo=quotient truncated toward zero, phi=remainder with the dividend's sign.
  - a=0x80000000, b=0xFFFFFFFF -> plo=0x80000000, phi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b=0, DIV/DIVU): the unit still goes busy for DIV_CYCLES; on completion hi/lo are unchanged.
- hi/lo change only at completion edges or MTHI/MTLO edges, never otherwise.
- No result is dropped; no output is combinational from start.

Optional Feature:
- Macro: MD_UNIT_MADD_EN.
- Defined:
  - op=110 (MADD): {hi,lo} <= {hi,lo} + signed(a)*signed(b), 64-bit wraparound.
  - op=111 (MSUB): {hi,lo} <= {hi,lo} - signed(a)*signed(b), 64-bit wraparound.
  - Both take MULT_CYCLES.
  - The accumulate uses {hi,lo} as of the start edge.
- Not defined: op 110/111 with start=1 are ignored; busy, hi and lo are unchanged.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE(-2), b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9(-7), b=2 -> busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 with prior hi=0x11, lo=0x22 -> busy high for 10 cycles; hi=0x11, lo=0x22 unchanged.
- MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles -> busy never asserts; hi=0x1234 and lo=0x5678 the next cycle. Also: MULT start, rst pulsed low at cycle 2 -> busy=0, hi=lo=0 immediately; no later update.
- With MD_UNIT_MADD_EN, hi=0, lo=10: MADD a=3, b=4 -> lo=22 after 5 cycles. Without the macro, the same stimulus -> busy stays 0 and lo=10.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO beside the EX-stage ALU.
// Define MD_UNIT_MADD_EN to enable MADD/MSUB accumulate into {HI,LO}; otherwise ops 110/111 are ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        phi_q, phi_d;
    logic [31:0]        plo_q, plo_d;
    logic               wr_q, wr_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

    logic signed [63:0] a_sx, b_sx, sprod;
    logic        [63:0] a_zx, b_zx, uprod;

    always_comb begin
        a_sx  = {{32{a[31]}}, a};
        b_sx  = {{32{b[31]}}, b};
        sprod = a_sx * b_sx;
        a_zx  = {32'd0, a};
        b_zx  = {32'd0, b};
        uprod = a_zx * b_zx;
    end

    // Divide by zero substitutes 1 so the datapath stays defined; the result is never written back.
    logic        b_zero;
    logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
    logic [31:0] mq, mr, sq, sr, uq, ur;

    always_comb begin
        b_zero   = (b == 32'd0);
        a_mag    = mag32(a);
        b_mag    = mag32(b);
        b_mag_nz = b_zero ? 32'd1 : b_mag;
        b_nz     = b_zero ? 32'd1 : b;
        mq       = a_mag / b_mag_nz;
        mr       = a_mag % b_mag_nz;
        sq       = (a[31] ^ b[31]) ? neg32(mq) : mq;
        sr       = a[31] ? neg32(mr) : mr;
        uq       = a / b_nz;
        ur       = a % b_nz;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {phi_d, plo_d} = sprod;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            wr_d    = 1'b1;
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            {phi_d, plo_d} = uprod;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            wr_d    = 1'b1;
                            state_d = RUN;
                        end
                        OP_DIV: begin
                            phi_d   = sr;
                            plo_d   = sq;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            wr_d    = ~b_zero;
                            state_d = RUN;
                        end
                        OP_DIVU: begin
                            phi_d   = ur;
                            plo_d   = uq;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            wr_d    = ~b_zero;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
`ifdef MD_UNIT_MADD_EN
                        // Accumulate base is {HI,LO} as of the start edge.
                        OP_MADD: begin
                            {phi_d, plo_d} = {hi_q, lo_q} + sprod;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            wr_d    = 1'b1;
                            state_d = RUN;
                        end
                        OP_MSUB: begin
                            {phi_d, plo_d} = {hi_q, lo_q} - sprod;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            wr_d    = 1'b1;
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (wr_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            wr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, results, MTHI/MTLO, reset abort, MADD/MSUB.
module tb_md_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    md_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle request at the current negedge; returns at the next negedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges with busy high (bounded) and note whether HI/LO moved meanwhile.
    task automatic wait_idle(output int n, output bit stable);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        n = 0;
        stable = 1'b1;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h, expected 00000000", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h, expected 00000000", lo); end
    endtask

    task automatic test_mult();
        int n; bit st;
        issue(3'b000, 32'hFFFFFFFE, 32'd3);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mult_busy_rise: got %b, expected 1", busy); end
        wait_idle(n, st);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL mult_cycles: got %0d, expected 5", n); end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL mult_hilo_stable: got %b, expected 1", st); end
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi: got %h, expected ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL mult_lo: got %h, expected fffffffa", lo); end
    endtask

    task automatic test_multu();
        int n; bit st;
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n, st);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL multu_cycles: got %0d, expected 5", n); end
        vectors++; if (hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi: got %h, expected fffffffe", hi); end
        vectors++; if (lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo: got %h, expected 00000001", lo); end
    endtask

    task automatic test_div();
        int n; bit st;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        wait_idle(n, st);
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL div_cycles: got %0d, expected 10", n); end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL div_hilo_stable: got %b, expected 1", st); end
        vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo: got %h, expected fffffffd", lo); end
        vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi: got %h, expected ffffffff", hi); end
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n, st);
        vectors++; if (lo !== 32'h80000000) begin miscompares++; $display("FAIL div_ovf_lo: got %h, expected 80000000", lo); end
        vectors++; if (hi !== 32'h00000000) begin miscompares++; $display("FAIL div_ovf_hi: got %h, expected 00000000", hi); end
    endtask

    task automatic test_divu();
        int n; bit st;
        issue(3'b011, 32'd100, 32'd7);
        wait_idle(n, st);
        vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_lo: got %h, expected 0000000e", lo); end
        vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_hi: got %h, expected 00000002", hi); end
        issue(3'b100, 32'h11, 32'd0);
        issue(3'b101, 32'h22, 32'd0);
        issue(3'b011, 32'd100, 32'd0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL divz_busy_rise: got %b, expected 1", busy); end
        wait_idle(n, st);
        vectors++; if (n !== 10) begin miscompares++; $display("FAIL divz_cycles: got %0d, expected 10", n); end
        vectors++; if (hi !== 32'h11) begin miscompares++; $display("FAIL divz_hi: got %h, expected 00000011", hi); end
        vectors++; if (lo !== 32'h22) begin miscompares++; $display("FAIL divz_lo: got %h, expected 00000022", lo); end
    endtask

    task automatic test_mthi_mtlo();
        issue(3'b100, 32'h1234, 32'd0);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy: got %b, expected 0", busy); end
        vectors++; if (hi !== 32'h1234) begin miscompares++; $display("FAIL mthi_hi: got %h, expected 00001234", hi); end
        issue(3'b101, 32'h5678, 32'd0);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mtlo_busy: got %b, expected 0", busy); end
        vectors++; if (hi !== 32'h1234) begin miscompares++; $display("FAIL mtlo_hi: got %h, expected 00001234", hi); end
        vectors++; if (lo !== 32'h5678) begin miscompares++; $display("FAIL mtlo_lo: got %h, expected 00005678", lo); end
    endtask

    task automatic test_back_to_back();
        int n; bit st;
        issue(3'b000, 32'd7, 32'd6);
        wait_idle(n, st);
        vectors++; if (lo !== 32'd42) begin miscompares++; $display("FAIL b2b_first_lo: got %h, expected 0000002a", lo); end
        issue(3'b001, 32'h00010000, 32'h00010000);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got %b, expected 1", busy); end
        wait_idle(n, st);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL b2b_cycles: got %0d, expected 5", n); end
        vectors++; if (hi !== 32'h1 || lo !== 32'h0) begin miscompares++; $display("FAIL b2b_result: got %h_%h, expected 00000001_00000000", hi, lo); end
    endtask

    task automatic test_start_while_busy();
        int n; bit st;
        issue(3'b000, 32'd2, 32'd3);
        start = 1'b1; op = 3'b101; a = 32'hBAD; b = 32'd0;
        @(negedge clk);
        op = 3'b010; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n, st);
        vectors++; if (n + 2 !== 5) begin miscompares++; $display("FAIL busy_ign_cycles: got %0d, expected 5", n + 2); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd6) begin miscompares++; $display("FAIL busy_ign_result: got %h_%h, expected 00000000_00000006", hi, lo); end
        repeat (12) @(negedge clk);
        vectors++; if (busy !== 1'b0 || lo !== 32'd6) begin miscompares++; $display("FAIL busy_ign_nolater: got busy=%b lo=%h, expected busy=0 lo=00000006", busy, lo); end
    endtask

    task automatic test_reset_mid_op();
        bit st;
        issue(3'b100, 32'hAA, 32'd0);
        issue(3'b000, 32'd5, 32'd5);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin miscompares++; $display("FAIL rst_mid_clear: got busy=%b hi=%h lo=%h, expected 0/0/0", busy, hi, lo); end
        @(negedge clk);
        rst = 1'b1;
        st = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) st = 1'b0;
        end
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL rst_mid_no_update: got %b, expected 1", st); end
    endtask

    task automatic test_madd();
        int n; bit st;
        issue(3'b100, 32'd0, 32'd0);
        issue(3'b101, 32'd10, 32'd0);
        issue(3'b110, 32'd3, 32'd4);
`ifdef MD_UNIT_MADD_EN
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL madd_busy: got %b, expected 1", busy); end
        wait_idle(n, st);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL madd_cycles: got %0d, expected 5", n); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd22) begin miscompares++; $display("FAIL madd_result: got %h_%h, expected 00000000_00000016", hi, lo); end
        issue(3'b111, 32'd3, 32'd10);
        wait_idle(n, st);
        vectors++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF8) begin miscompares++; $display("FAIL msub_result: got %h_%h, expected ffffffff_fffffff8", hi, lo); end
`else
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL madd_off_busy: got %b, expected 0", busy); end
        issue(3'b111, 32'd3, 32'd10);
        wait_idle(n, st);
        vectors++; if (n !== 0) begin miscompares++; $display("FAIL msub_off_busy: got %0d, expected 0", n); end
        repeat (6) @(negedge clk);
        vectors++; if (hi !== 32'd0 || lo !== 32'd10) begin miscompares++; $display("FAIL madd_off_hilo: got %h_%h, expected 00000000_0000000a", hi, lo); end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_mult();
        test_multu();
        test_div();
        test_divu();
        test_mthi_mtlo();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_op();
        test_madd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
